// File: rtl/cordic_sched_pkg.sv
// Shared widths and helpers for the cordic request scheduler.
package cordic_sched_pkg;

   localparam int THETA_W    = 16;
   localparam int THETA_FRAC = 13;
   localparam int RES_W      = 16;
   localparam int RES_FRAC   = 14;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cordic_sched_fifo.sv
// First-word-fall-through result buffer; reads as zero while empty.
module cordic_sched_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             do_pop, full;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign do_pop = pop && !empty;
   assign rdata  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

   // When full, a same-cycle pop frees the slot the push lands in.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wdata;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !do_pop));

endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one external pipelined cordic among N_REQ requesters.
module cordic_sched
   import cordic_sched_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int CORDIC_LAT = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [THETA_W*N_REQ-1:0]    req_theta,
   output logic [N_REQ-1:0]            req_ready,
   output logic [THETA_W-1:0]          cor_theta,
   input  logic [RES_W-1:0]            cor_cos,
   input  logic [RES_W-1:0]            cor_sin,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [id_w(N_REQ)-1:0]      out_id,
   output logic [RES_W-1:0]            out_cos,
   output logic [RES_W-1:0]            out_sin,
   output logic                        busy
);

   localparam int ID_W  = id_w(N_REQ);
   localparam int DEPTH = CORDIC_LAT + 1;
   localparam int CW    = $clog2(DEPTH+1);
   localparam int OW    = $clog2(2*DEPTH+1);
   localparam int FW    = ID_W + 2*RES_W;

   logic [ID_W-1:0]    rr_ptr, grant_idx;
   logic [ID_W:0]      cand;
   logic               found, grant, credit_ok, pop;
   logic [CORDIC_LAT-1:0] tag_v;
   logic [ID_W-1:0]    tag_id [CORDIC_LAT];
   logic [OW-1:0]      inflight, occupancy;
   logic [CW-1:0]      fifo_count;
   logic               fifo_empty;
   logic [FW-1:0]      fifo_rdata;
   logic [THETA_W-1:0] theta_arr [N_REQ];

   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ))
            cand = cand - (ID_W+1)'(N_REQ);
         if (!found && req_valid[cand[ID_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int s = 0; s < CORDIC_LAT; s++)
         inflight = inflight + OW'(tag_v[s]);
   end

   // Everything accepted but not yet popped must fit in the result buffer.
   assign pop       = out_valid && out_ready;
   assign occupancy = inflight + OW'(fifo_count) - OW'(pop);
   assign credit_ok = occupancy < OW'(DEPTH);
   assign grant     = rst && found && credit_ok;

   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         theta_arr[i] = req_theta[i*THETA_W +: THETA_W];
   end

   assign cor_theta = grant ? theta_arr[grant_idx] : '0;
   assign req_ready = grant ? (N_REQ'(1) << grant_idx) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= '0;
         tag_v  <= '0;
         for (int s = 0; s < CORDIC_LAT; s++)
            tag_id[s] <= '0;
      end else begin
         if (grant)
            rr_ptr <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
         tag_v[0]  <= grant;
         tag_id[0] <= grant_idx;
         for (int s = 1; s < CORDIC_LAT; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   cordic_sched_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_v[CORDIC_LAT-1]),
      .wdata ({tag_id[CORDIC_LAT-1], cor_cos, cor_sin}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign out_valid                  = !fifo_empty;
   assign {out_id, out_cos, out_sin} = fifo_rdata;
   assign busy                       = (|tag_v) || !fifo_empty;

endmodule
